// File: rtl/mips_wb_writer_pkg.sv
// Shared register-file constants for the MIPS write-back path.
// WB_DEPTH is the default queue depth for the write-back writer.
package mips_wb_writer_pkg;

  localparam int REG_ADDR_LEN = 5;
  localparam int REG_LENGTH   = 32;
  localparam int WB_DEPTH     = 4;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } wb_en_e;

endpackage

// File: rtl/mips_wb_fifo.sv
// Circular write-back queue with two ordered push ports (push0 lands before push1) and one pop.
// Entries are exposed oldest-first so the scoreboard and forward scans can rely on age order.
module mips_wb_fifo
  import mips_wb_writer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_ADDR_LEN,
  parameter int DW    = REG_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  logic [AW-1:0]          addr0,
  input  logic [DW-1:0]          data0,
  input  logic                   push1,
  input  logic [AW-1:0]          addr1,
  input  logic [DW-1:0]          data1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       ent_valid,
  output logic [AW-1:0]          ent_addr [DEPTH],
  output logic [DW-1:0]          ent_data [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;

  assign wr_ptr_next = wr_ptr + PW'(1);

  // When only push1 fires it takes the first free slot, otherwise the one after push0.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_addr[wr_ptr] <= addr0;
      mem_data[wr_ptr] <= data0;
    end
    if (push1) begin
      mem_addr[push0 ? wr_ptr_next : wr_ptr] <= addr1;
      mem_data[push0 ? wr_ptr_next : wr_ptr] <= data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k] = CW'(k) < count;
      ent_addr[k]  = mem_addr[rd_ptr + PW'(k)];
      ent_data[k]  = mem_data[rd_ptr + PW'(k)];
    end
  end

endmodule

// File: rtl/mips_wb_writer.sv
// Write-back writer: queues results from sources A/B, issues one registered regfile write per
// cycle and flags pending writes for hazard stalls. Define MIPS_WB_FWD_EN to enable forwarding.
module mips_wb_writer
  import mips_wb_writer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_ADDR_LEN,
  parameter int DW    = REG_LENGTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aValid,
  input  logic [AW-1:0] aAddr,
  input  logic [DW-1:0] aData,
  output logic          aReady,
  input  logic          bValid,
  input  logic [AW-1:0] bAddr,
  input  logic [DW-1:0] bData,
  output logic          bReady,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wData,
  input  logic [AW-1:0] qAddr0,
  input  logic [AW-1:0] qAddr1,
  output logic          qBusy0,
  output logic          qBusy1,
  output logic          fwdVal0,
  output logic [DW-1:0] fwdData0,
  output logic          fwdVal1,
  output logic [DW-1:0] fwdData1,
  output logic          empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic             push_a;
  logic             push_b;
  logic             pop;

  // Ready depends only on the registered count, so a same-cycle pop never frees space early.
  assign free   = CW'(DEPTH) - count;
  assign aReady = free != '0;
  assign bReady = (free >= CW'(2)) | ((free == CW'(1)) & ~aValid);

  // Writes to $0 are accepted but dropped here so they never occupy a slot or look busy.
  assign push_a = aValid & aReady & (aAddr != '0);
  assign push_b = bValid & bReady & (bAddr != '0);
  assign pop    = count != '0;

  mips_wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push0    (push_a),
    .addr0    (aAddr),
    .data0    (aData),
    .push1    (push_b),
    .addr1    (bAddr),
    .data1    (bData),
    .pop      (pop),
    .count    (count),
    .ent_valid(ent_valid),
    .ent_addr (ent_addr),
    .ent_data (ent_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= DISABLE;
      wAddr <= '0;
      wData <= '0;
    end else if (pop) begin
      we    <= ENABLE;
      wAddr <= ent_addr[0];
      wData <= ent_data[0];
    end else begin
      we    <= DISABLE;
    end
  end

  // The output register still counts as pending until the regfile captures it.
  always_comb begin
    qBusy0 = (qAddr0 != '0) & we & (wAddr == qAddr0);
    qBusy1 = (qAddr1 != '0) & we & (wAddr == qAddr1);
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && (qAddr0 != '0) && (ent_addr[k] == qAddr0)) qBusy0 = 1'b1;
      if (ent_valid[k] && (qAddr1 != '0) && (ent_addr[k] == qAddr1)) qBusy1 = 1'b1;
    end
  end

`ifdef MIPS_WB_FWD_EN
  // Oldest-to-newest scan: the youngest matching entry overrides, output register is fallback.
  always_comb begin
    fwdVal0  = 1'b0;
    fwdData0 = '0;
    fwdVal1  = 1'b0;
    fwdData1 = '0;
    if ((qAddr0 != '0) && we && (wAddr == qAddr0)) begin
      fwdVal0  = 1'b1;
      fwdData0 = wData;
    end
    if ((qAddr1 != '0) && we && (wAddr == qAddr1)) begin
      fwdVal1  = 1'b1;
      fwdData1 = wData;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && (qAddr0 != '0) && (ent_addr[k] == qAddr0)) begin
        fwdVal0  = 1'b1;
        fwdData0 = ent_data[k];
      end
      if (ent_valid[k] && (qAddr1 != '0) && (ent_addr[k] == qAddr1)) begin
        fwdVal1  = 1'b1;
        fwdData1 = ent_data[k];
      end
    end
  end
`else
  assign fwdVal0  = 1'b0;
  assign fwdData0 = '0;
  assign fwdVal1  = 1'b0;
  assign fwdData1 = '0;
`endif

  assign empty = (count == '0) & ~we;

endmodule

// File: tb/tb_mips_wb_writer.sv
// Bench for mips_wb_writer: queue-based reference model checked every cycle, plus directed
// literal checks; a second DEPTH=2 instance exercises the full condition.
module tb_mips_wb_writer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          aValid, bValid, aReady, bReady;
  logic [AW-1:0] aAddr, bAddr, wAddr, qAddr0, qAddr1;
  logic [DW-1:0] aData, bData, wData, fwdData0, fwdData1;
  logic          we, qBusy0, qBusy1, fwdVal0, fwdVal1, empty;

  logic          d2_a_valid, d2_b_valid, d2_a_ready, d2_b_ready;
  logic [AW-1:0] d2_a_addr, d2_b_addr, d2_w_addr, d2_q0, d2_q1;
  logic [DW-1:0] d2_a_data, d2_b_data, d2_w_data, d2_fwd_data0, d2_fwd_data1;
  logic          d2_we, d2_busy0, d2_busy1, d2_fwd_val0, d2_fwd_val1, d2_empty;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  mips_wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
    .we(we), .wAddr(wAddr), .wData(wData),
    .qAddr0(qAddr0), .qAddr1(qAddr1), .qBusy0(qBusy0), .qBusy1(qBusy1),
    .fwdVal0(fwdVal0), .fwdData0(fwdData0), .fwdVal1(fwdVal1), .fwdData1(fwdData1),
    .empty(empty)
  );

  mips_wb_writer #(.DEPTH(2), .AW(AW), .DW(DW)) dut2 (
    .clk(clk), .rst(rst),
    .aValid(d2_a_valid), .aAddr(d2_a_addr), .aData(d2_a_data), .aReady(d2_a_ready),
    .bValid(d2_b_valid), .bAddr(d2_b_addr), .bData(d2_b_data), .bReady(d2_b_ready),
    .we(d2_we), .wAddr(d2_w_addr), .wData(d2_w_data),
    .qAddr0(d2_q0), .qAddr1(d2_q1), .qBusy0(d2_busy0), .qBusy1(d2_busy1),
    .fwdVal0(d2_fwd_val0), .fwdData0(d2_fwd_data0), .fwdVal1(d2_fwd_val1),
    .fwdData1(d2_fwd_data1), .empty(d2_empty)
  );

  function automatic void check_output(input string name, input logic [DW-1:0] actual,
                                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: pending results in arrival order plus the last issued write.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(posedge clk) begin
    int   free;
    ent_t head;
    if (rst) begin
      mq.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      free = DEPTH - mq.size();
      if (mq.size() > 0) begin
        head   = mq.pop_front();
        m_we   = 1'b1;
        m_addr = head.addr;
        m_data = head.data;
      end else begin
        m_we = 1'b0;
      end
      if (aValid && free >= 1 && aAddr != 0) mq.push_back('{aAddr, aData});
      if (bValid && (free >= 2 || (free == 1 && !aValid)) && bAddr != 0)
        mq.push_back('{bAddr, bData});
    end
  end

  function automatic logic exp_busy(input logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    if (m_we && m_addr == q) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW:0] exp_fwd(input logic [AW-1:0] q);
    if (q == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == q) return {1'b1, mq[i].data};
    if (m_we && m_addr == q) return {1'b1, m_data};
    return '0;
  endfunction

  always @(negedge clk) begin
    int          free;
    logic [DW:0] f0, f1;
    if (check_en) begin
      free = DEPTH - mq.size();
      check_output("aReady", aReady, free >= 1);
      check_output("bReady", bReady, free >= 2 || (free == 1 && !aValid));
      check_output("we", we, m_we);
      check_output("wAddr", wAddr, m_addr);
      check_output("wData", wData, m_data);
      check_output("qBusy0", qBusy0, exp_busy(qAddr0));
      check_output("qBusy1", qBusy1, exp_busy(qAddr1));
      check_output("empty", empty, mq.size() == 0 && !m_we);
`ifdef MIPS_WB_FWD_EN
      f0 = exp_fwd(qAddr0);
      f1 = exp_fwd(qAddr1);
`else
      f0 = '0;
      f1 = '0;
`endif
      check_output("fwdVal0", fwdVal0, f0[DW]);
      check_output("fwdData0", fwdData0, f0[DW-1:0]);
      check_output("fwdVal1", fwdVal1, f1[DW]);
      check_output("fwdData1", fwdData1, f1[DW-1:0]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    aValid = av; aAddr = aa; aData = ad;
    bValid = bv; bAddr = ba; bData = bd;
  endtask

  task automatic idle;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && !empty; i++) tick;
    check_output("drain_empty", empty, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    idle;
    qAddr0 = '0; qAddr1 = '0;
    d2_a_valid = 0; d2_a_addr = '0; d2_a_data = '0;
    d2_b_valid = 0; d2_b_addr = '0; d2_b_data = '0;
    d2_q0 = '0; d2_q1 = '0;
    repeat (2) tick;
    rst = 1'b0;

    check_output("rst_we", we, 1'b0);
    check_output("rst_wAddr", wAddr, '0);
    check_output("rst_wData", wData, '0);
    check_output("rst_aReady", aReady, 1'b1);
    check_output("rst_bReady", bReady, 1'b1);
    check_output("rst_empty", empty, 1'b1);
    check_en = 1'b1;

    // Full boundary on the DEPTH=2 instance.
    d2_a_valid = 1; d2_a_addr = 5'd3; d2_a_data = 32'h11;
    d2_b_valid = 1; d2_b_addr = 5'd4; d2_b_data = 32'h22;
    d2_q0 = 5'd4;
    tick;
    d2_a_valid = 0; d2_b_valid = 0;
    check_output("d2_full_aReady", d2_a_ready, 1'b0);
    check_output("d2_full_bReady", d2_b_ready, 1'b0);
    check_output("d2_busy0", d2_busy0, 1'b1);
    tick;
    check_output("d2_we1", d2_we, 1'b1);
    check_output("d2_wAddr1", d2_w_addr, 5'd3);
    check_output("d2_wData1", d2_w_data, 32'h11);
    check_output("d2_free1_bReady", d2_b_ready, 1'b1);
    d2_a_valid = 1; d2_a_addr = 5'd6; d2_a_data = 32'h33;
    d2_b_valid = 1; d2_b_addr = 5'd8; d2_b_data = 32'h44;
    #1;
    check_output("d2_free1_aReady", d2_a_ready, 1'b1);
    check_output("d2_free1_bReady_a", d2_b_ready, 1'b0);
    tick;
    d2_a_valid = 0; d2_b_valid = 0;
    check_output("d2_wAddr2", d2_w_addr, 5'd4);
    check_output("d2_wData2", d2_w_data, 32'h22);
    tick;
    check_output("d2_wAddr3", d2_w_addr, 5'd6);
    check_output("d2_wData3", d2_w_data, 32'h33);
    tick;
    check_output("d2_no_b_write", d2_we, 1'b0);
    check_output("d2_empty", d2_empty, 1'b1);

    // Single write: two-cycle latency, one-cycle pulse, then hold.
    apply_stimulus(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    #1;
    check_output("t1_aReady", aReady, 1'b1);
    tick;
    idle;
    check_output("t1_we_early", we, 1'b0);
    tick;
    check_output("t1_we", we, 1'b1);
    check_output("t1_wAddr", wAddr, 5'd5);
    check_output("t1_wData", wData, 32'hDEADBEEF);
    tick;
    check_output("t1_we_off", we, 1'b0);
    check_output("t1_wData_hold", wData, 32'hDEADBEEF);

    // Same-address pair: A's value first, B's value last.
    apply_stimulus(1, 5'd7, 32'd1, 1, 5'd7, 32'd2);
    tick;
    idle;
    tick;
    check_output("t2_first_addr", wAddr, 5'd7);
    check_output("t2_first_data", wData, 32'd1);
    tick;
    check_output("t2_second_we", we, 1'b1);
    check_output("t2_second_data", wData, 32'd2);
    tick;
    check_output("t2_we_off", we, 1'b0);

    // Fill to count 3, then free==1 arbitration.
    apply_stimulus(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    tick;
    apply_stimulus(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    tick;
    apply_stimulus(1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
    #1;
    check_output("t3_aReady", aReady, 1'b1);
    check_output("t3_bReady_blocked", bReady, 1'b0);
    tick;
    apply_stimulus(0, '0, '0, 1, 5'd16, 32'h160);
    #1;
    check_output("t3_bReady_alone", bReady, 1'b1);
    tick;
    idle;
    drain;

    // Register $0 is accepted and discarded.
    apply_stimulus(1, 5'd0, 32'hFFFF, 0, '0, '0);
    #1;
    check_output("t4_aReady", aReady, 1'b1);
    tick;
    idle;
    check_output("t4_qBusy0", qBusy0, 1'b0);
    tick;
    check_output("t4_no_we", we, 1'b0);
    tick;
    check_output("t4_no_we2", we, 1'b0);
    check_output("t4_empty", empty, 1'b1);

    // Hazard tracking on $9 through queue and output register.
    qAddr1 = 5'd9;
    apply_stimulus(1, 5'd9, 32'h12345678, 0, '0, '0);
    #1;
    check_output("t5_busy_before", qBusy1, 1'b0);
    tick;
    idle;
    check_output("t5_busy_queued", qBusy1, 1'b1);
`ifdef MIPS_WB_FWD_EN
    check_output("t5_fwd_val", fwdVal1, 1'b1);
    check_output("t5_fwd_data", fwdData1, 32'h12345678);
`endif
    tick;
    check_output("t5_busy_outreg", qBusy1, 1'b1);
    check_output("t5_wAddr", wAddr, 5'd9);
    tick;
    check_output("t5_busy_clear", qBusy1, 1'b0);
    apply_stimulus(1, 5'd9, 32'h111, 1, 5'd9, 32'h222);
    tick;
    idle;
    tick;
`ifdef MIPS_WB_FWD_EN
    check_output("t5_fwd_youngest", fwdData1, 32'h222);
`endif
    drain;
    qAddr1 = '0;

    // Reset with three entries queued.
    apply_stimulus(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
    tick;
    apply_stimulus(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
    tick;
    idle;
    qAddr0 = 5'd22; qAddr1 = 5'd23;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_output("t6_we", we, 1'b0);
    check_output("t6_empty", empty, 1'b1);
    check_output("t6_busy0", qBusy0, 1'b0);
    check_output("t6_busy1", qBusy1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_output("t6_no_we", we, 1'b0);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
